// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode handshake bundle for inst_fetch_queue.
// The queue takes the slave modport; the fetch/decode side takes the master modport.
interface inst_fetch_queue_if #(
    parameter int BUS_W = 32,
    parameter int DEPTH = 2
);
    logic                     flush;
    logic                     fetch_valid;
    logic                     fetch_ready;
    logic [BUS_W-1:0]         fetch_inst;
    logic [BUS_W-1:0]         fetch_pc;
    logic                     dec_valid;
    logic                     dec_ready;
    logic [BUS_W-1:0]         dec_inst;
    logic [BUS_W-1:0]         dec_pc;
    logic [2:0]               dec_imm_fmt;
    logic                     dec_illegal;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  flush, fetch_valid, fetch_inst, fetch_pc, dec_ready,
        output fetch_ready, dec_valid, dec_inst, dec_pc, dec_imm_fmt, dec_illegal, count
    );

    modport master (
        output flush, fetch_valid, fetch_inst, fetch_pc, dec_ready,
        input  fetch_ready, dec_valid, dec_inst, dec_pc, dec_imm_fmt, dec_illegal, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction/PC FIFO between fetch and decode with enqueue-time opcode classification.
// Optional macro IFQ_BYPASS_EN: an empty queue forwards the fetch word straight to decode.
module inst_fetch_queue #(
    parameter int DEPTH = 2,
    parameter int BUS_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inst_fetch_queue_if.slave    ifq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [BUS_W-1:0] inst;
        logic [BUS_W-1:0] pc;
        logic [2:0]       imm_fmt;
        logic             illegal;
    } entry_t;

    entry_t          mem_reg [DEPTH];
    logic [PW-1:0]   head_reg, head_next;
    logic [PW-1:0]   tail_reg, tail_next;
    logic [CW-1:0]   count_reg, count_next;

    entry_t          fetch_entry;
    entry_t          head_entry;
    logic            full;
    logic            empty;
    logic            bypass;
    logic            enq;
    logic            deq;

    function automatic entry_t classify(input logic [BUS_W-1:0] inst, input logic [BUS_W-1:0] pc);
        entry_t e;
        e.inst    = inst;
        e.pc      = pc;
        e.imm_fmt = 3'd0;
        e.illegal = 1'b0;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: e.imm_fmt = 3'd1;
            7'b0100011:                                     e.imm_fmt = 3'd2;
            7'b1100011:                                     e.imm_fmt = 3'd3;
            7'b0110111, 7'b0010111:                         e.imm_fmt = 3'd4;
            7'b1101111:                                     e.imm_fmt = 3'd5;
            7'b0110011, 7'b0001111:                         e.imm_fmt = 3'd0;
            default:                                        e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    assign fetch_entry     = classify(ifq.fetch_inst, ifq.fetch_pc);
    assign full            = (count_reg == FULL_CNT);
    assign empty           = (count_reg == '0);
    assign ifq.fetch_ready = !ifq.flush && !full;

`ifdef IFQ_BYPASS_EN
    assign bypass = !ifq.flush && empty && ifq.fetch_valid;
`else
    assign bypass = 1'b0;
`endif

    assign ifq.dec_valid   = !ifq.flush && (!empty || bypass);
    assign head_entry      = bypass ? fetch_entry : mem_reg[head_reg];
    assign ifq.dec_inst    = head_entry.inst;
    assign ifq.dec_pc      = head_entry.pc;
    assign ifq.dec_imm_fmt = head_entry.imm_fmt;
    assign ifq.dec_illegal = head_entry.illegal;
    assign ifq.count       = count_reg;

    // A bypassed word consumed in the same cycle never touches storage.
    assign enq = ifq.fetch_valid && ifq.fetch_ready && !(bypass && ifq.dec_ready);
    assign deq = ifq.dec_valid && ifq.dec_ready && !bypass;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (ifq.flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (enq) tail_next = tail_reg + PW'(1);
            if (deq) head_next = head_reg + PW'(1);
            case ({enq, deq})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (enq) begin
            mem_reg[tail_reg] <= fetch_entry;
        end
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Decode-side instruction buffer for the RVX core: a small FIFO of instruction/PC pairs between the fetch unit and the decode stage. It decouples fetch from decode stalls with a valid/ready handshake on both sides, classifies each instruction's immediate format and legality at enqueue time, and holds the head entry stable while decode and the immediate generator consume it. A synchronous flush from the branch/jump resolution logic discards all buffered entries.

## Interface
- `DEPTH`, 2: number of entries; legal values 2 or 4.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous discard of all entries, including any enqueue attempted in the same cycle.
- `fetch_valid`  in  1  fetch presents an instruction.
- `fetch_ready`  out  1  queue accepts an instruction: `!flush && count < DEPTH`.
- `fetch_inst`  in  `BUS_W`  instruction word.
- `fetch_pc`  in  `BUS_W`  PC of `fetch_inst`.
- `dec_valid`  out  1  head entry valid: `!flush && count != 0` (see Configuration for bypass).
- `dec_ready`  in  1  decode consumes the head this cycle.
- `dec_inst`  out  `BUS_W`  head instruction word.
- `dec_pc`  out  `BUS_W`  head PC.
- `dec_imm_fmt`  out  3  head immediate format: 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J.
- `dec_illegal`  out  1  head opcode is not in the supported set.
- `count`  out  `$clog2(DEPTH)+1`  current occupancy.

## Operation
- Storage: DEPTH entries of {inst, pc, imm_fmt, illegal}; head/tail pointers of `$clog2(DEPTH)` bits wrap modulo DEPTH; `count` register tracks occupancy.
- Enqueue when `fetch_valid && fetch_ready`: write the entry at tail, advance tail.
- Dequeue when `dec_valid && dec_ready`: advance head.
- Simultaneous enqueue and dequeue: both pointers advance, `count` unchanged. When full, `fetch_ready`=0 regardless of `dec_ready`, so no enqueue occurs in that cycle.
- Classification is computed from `fetch_inst[6:0]` at enqueue and stored with the entry:
  - I (1): 0010011, 0000011, 1100111, 1110011.
  - S (2): 0100011. B (3): 1100011. U (4): 0110111, 0010111. J (5): 1101111.
  - None (0), legal: 0110011, 0001111.
  - Any other opcode: fmt 0 and illegal=1. The entry is still queued and delivered; decode raises the trap.
- `dec_*` data outputs are a combinational read of the head entry. They are stable while `dec_valid && !dec_ready`.
- Flush: on the next edge, head=tail=0 and `count`=0. While `flush`=1, `fetch_ready` and `dec_valid` are forced to 0, so no handshake completes in the flush cycle.
- Reset (`rst_n`=0, asynchronous): pointers 0, `count`=0, all storage 0. Consequently `dec_valid`=0, `dec_inst`=0, `dec_pc`=0, `dec_imm_fmt`=0, `dec_illegal`=0, and `fetch_ready`=1 unless `flush` is high. A reset mid-operation drops every entry.

## Timing
- Enqueue to `dec_valid`: 1 cycle when the queue is empty (0 cycles with bypass).
- Throughput: one enqueue and one dequeue per cycle sustained.
- `fetch_ready` depends only on registered `count` and `flush`; it has no combinational path from `dec_ready`.
- After flush deasserts, the first enqueue is accepted in the same cycle it is presented.

## Configuration
- `IFQ_BYPASS_EN` defined: when `count`=0 and `fetch_valid`=1 (and `flush`=0), `dec_valid`=1 and the `dec_*` outputs pass `fetch_inst`, `fetch_pc` and their live classification directly.
  - If `dec_ready`=1 in that cycle, nothing is written.
  - Otherwise the entry is enqueued normally.
  - This creates a combinational path from `fetch_valid` to `dec_valid`.
- `IFQ_BYPASS_EN` undefined: `dec_valid` is purely registered-state driven, with 1-cycle minimum latency.

## Test plan
- Reset, then enqueue 0x00500093 @ PC 0x0, with `dec_ready`=1 -> next cycle `dec_valid`=1, `dec_inst`=0x00500093, `dec_imm_fmt`=1, `dec_illegal`=0; `count` returns to 0 after the consume.
- With `dec_ready`=0, enqueue 0x00112023 then 0xFE000EE3 (DEPTH=2) -> `count`=2, `fetch_ready`=0; a third `fetch_valid` is not accepted. Then raise `dec_ready` -> outputs fmt 2 then fmt 3, in order.
- Full queue with `fetch_valid`=1 and `dec_ready`=1 in the same cycle -> one dequeue, no enqueue; `count` goes 2->1.
- With 2 entries held, assert `flush` together with `fetch_valid` -> `dec_valid`=0 and `fetch_ready`=0 during flush; `count`=0 next cycle; the flushed-cycle instruction is never delivered.
- Enqueue 0x0000007F -> `dec_illegal`=1, `dec_imm_fmt`=0. Enqueue 0x0000006F -> `dec_imm_fmt`=5. Pulse `rst_n` low with 1 entry queued -> all outputs 0 immediately.
- DEPTH=4, 10 back-to-back enqueue/dequeue pairs -> pointers wrap, order preserved. With `IFQ_BYPASS_EN`, empty queue and `dec_ready`=1 -> `dec_valid` asserted in the same cycle as `fetch_valid`.
